// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types for the S-array RAM sequential reader
package rc4_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} reader_state_t;
endpackage

// File: rtl/reader_fifo.sv
// reader_fifo: first-word-fall-through synchronous FIFO with occupancy count
module reader_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // storage array, written at the tail
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  // pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/ram_sequential_reader.sv
// ram_sequential_reader: streams RAM words START_INDEX..END_INDEX on a valid/ready port
module ram_sequential_reader
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH    = 8,
  parameter int RAM_LENGTH   = 8,
  parameter int START_INDEX  = 0,
  parameter int END_INDEX    = 255,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  finished,
  output logic [RAM_LENGTH-1:0] address,
  input  logic [RAM_WIDTH-1:0]  ram_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RAM_WIDTH-1:0]  out_data,
  output logic [RAM_LENGTH-1:0] out_index
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = RAM_WIDTH + RAM_LENGTH;
  localparam logic [RAM_LENGTH-1:0] START_A = RAM_LENGTH'(START_INDEX);
  localparam logic [RAM_LENGTH-1:0] END_A   = RAM_LENGTH'(END_INDEX);
  reader_state_t         r_state, w_next;
  logic                  r_start_d, w_start_edge, w_credit, w_issue, w_done, w_pop;
  logic                  r_finished, r_out_valid;
  logic [RAM_LENGTH-1:0] r_address, r_out_index;
  logic [RAM_WIDTH-1:0]  r_out_data;
  logic [READ_LATENCY-1:0] r_sr_v;
  logic [RAM_LENGTH-1:0] r_sr_idx [READ_LATENCY];
  logic [CW-1:0]         w_in_flight, w_fifo_count;
  logic                  w_fifo_empty, w_fifo_full;
  logic [FW-1:0]         w_fifo_data;
  assign w_start_edge = start && !r_start_d;
  assign busy      = r_state != IDLE;
  assign finished  = r_finished;
  assign address   = r_address;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign w_pop     = !w_fifo_empty && (!r_out_valid || out_ready);
  // reads still travelling through the RAM pipeline
  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_in_flight = w_in_flight + CW'(r_sr_v[i]);
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // next-state: a read is issued only while buffer plus in-flight reads leave room
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start_edge ? ISSUE : IDLE;
      ISSUE:   w_next = (w_credit && r_address == END_A) ? DRAIN : ISSUE;
      DRAIN:   w_next = w_done ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // FSM outputs: issue strobe and pass completion once the last word leaves
  always_comb begin
    w_credit = (w_fifo_count + w_in_flight) < CW'(FIFO_DEPTH) && !w_fifo_full;
    w_issue  = r_state == ISSUE && w_credit;
    w_done   = r_state == DRAIN && w_in_flight == '0 && w_fifo_empty && (!r_out_valid || out_ready);
  end
  // start history, finished pulse and read address; address stops at END_INDEX
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_start_d  <= 1'b0;
      r_finished <= 1'b0;
      r_address  <= START_A;
    end else begin
      r_start_d  <= start;
      r_finished <= w_done;
      if (r_state == IDLE && w_start_edge) r_address <= START_A;
      else if (w_issue && r_address != END_A) r_address <= r_address + RAM_LENGTH'(1);
    end
  // latency shift register tagging each read with its address
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sr_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_sr_idx[i] <= '0;
    end else begin
      r_sr_v[0]   <= w_issue;
      r_sr_idx[0] <= r_address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_sr_v[i]   <= r_sr_v[i-1];
        r_sr_idx[i] <= r_sr_idx[i-1];
      end
    end
  reader_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (r_sr_v[READ_LATENCY-1]),
    .i_data  ({r_sr_idx[READ_LATENCY-1], ram_out}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );
  // output register: refills from the FIFO when empty or when its word is taken
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_fifo_data[RAM_WIDTH-1:0];
      r_out_index <= w_fifo_data[FW-1:RAM_WIDTH];
    end else if (out_ready) r_out_valid <= 1'b0;
endmodule

// File: tb/tb_ram_sequential_reader.sv
// tb_ram_sequential_reader: scoreboard bench for three reader configurations
module tb_ram_sequential_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic strt [3], rdy [3], busy [3], fin_p [3], vld [3];
  logic [7:0] addr [3], ramd [3], dat [3], idx [3];
  logic [7:0] b1;
  logic [15:0] q [3][$];
  logic [15:0] e;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int fin [3], xfer [3], t0 [3], lat_exp [3], len_chk [3];
  logic seen [3], pv [3], pr [3], pb [3];
  logic [15:0] pw [3];

  ram_sequential_reader u_a (
    .clk(clk), .reset(rst_n), .start(strt[0]), .busy(busy[0]), .finished(fin_p[0]),
    .address(addr[0]), .ram_out(ramd[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
    .out_data(dat[0]), .out_index(idx[0]));
  ram_sequential_reader #(.READ_LATENCY(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(rst_n), .start(strt[1]), .busy(busy[1]), .finished(fin_p[1]),
    .address(addr[1]), .ram_out(ramd[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
    .out_data(dat[1]), .out_index(idx[1]));
  ram_sequential_reader #(.START_INDEX(17), .END_INDEX(17)) u_c (
    .clk(clk), .reset(rst_n), .start(strt[2]), .busy(busy[2]), .finished(fin_p[2]),
    .address(addr[2]), .ram_out(ramd[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
    .out_data(dat[2]), .out_index(idx[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: S[i]=i for a and b (b has two-cycle latency), c holds 0xA5 at 17
  always @(posedge clk) begin
    ramd[0] <= addr[0];
    b1      <= addr[1];
    ramd[1] <= b1;
    ramd[2] <= (addr[2] == 8'd17) ? 8'hA5 : addr[2];
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", nm, i, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard on each transfer and checks stream rules and timing
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n) begin
        if (pv[i] && !pr[i])
          chk("stall_hold", i, {15'b0, vld[i], idx[i], dat[i]}, {15'b0, 1'b1, pw[i]});
        if (busy[i] && !pb[i]) begin
          t0[i] = cyc;
          seen[i] = 1'b0;
        end
        if (vld[i] && !seen[i]) begin
          seen[i] = 1'b1;
          chk("first_valid_lat", i, cyc - t0[i], lat_exp[i]);
        end
        if (vld[i] && rdy[i]) begin
          if (q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_word[%0d] got %0h expected none", i, {idx[i], dat[i]});
          end else begin
            e = q[i].pop_front();
            chk("word", i, {16'b0, idx[i], dat[i]}, {16'b0, e});
            xfer[i]++;
          end
        end
        if (fin_p[i]) begin
          fin[i]++;
          chk("busy_at_finish", i, 32'(busy[i]), 0);
          chk("queue_drained", i, q[i].size(), 0);
          if (len_chk[i] != 0) chk("pass_length", i, cyc - t0[i], len_chk[i]);
        end
        if (i == 2 && busy[i]) chk("addr_bound", i, 32'(addr[i]), 17);
      end
      pv[i] = vld[i];
      pr[i] = rdy[i];
      pb[i] = busy[i];
      pw[i] = {idx[i], dat[i]};
    end
  end

  task automatic push_all(input int i);
    for (int k = 0; k < 256; k++) q[i].push_back({8'(k), 8'(k)});
  endtask

  task automatic pulse(input int i);
    @(posedge clk); #1 strt[i] = 1'b1;
    @(posedge clk); #1 strt[i] = 1'b0;
  endtask

  task automatic wait_fin(input int i, input int budget);
    int f0, n;
    f0 = fin[i];
    n = 0;
    while (fin[i] == f0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("finish_wait", i, 32'(fin[i] != f0), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int f0, n, x0;
    for (int i = 0; i < 3; i++) begin
      strt[i] = 1'b0; fin[i] = 0; xfer[i] = 0; t0[i] = 0;
      seen[i] = 1'b1; pv[i] = 1'b0; pr[i] = 1'b0; pb[i] = 1'b0; pw[i] = '0;
    end
    lat_exp = '{3, 4, 3};
    len_chk = '{259, 0, 4};
    rdy = '{1'b1, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 0);
      chk("rst_finished", i, 32'(fin_p[i]), 0);
      chk("rst_valid", i, 32'(vld[i]), 0);
      chk("rst_out", i, {16'b0, idx[i], dat[i]}, 0);
    end
    chk("rst_addr", 0, 32'(addr[0]), 0);
    chk("rst_addr", 2, 32'(addr[2]), 17);
    rst_n = 1'b1;
    // full pass with out_ready held high
    push_all(0);
    pulse(0);
    wait_fin(0, 400);
    // backpressure: stalled stream stops issuing after five reads
    rdy[0] = 1'b0;
    len_chk[0] = 0;
    push_all(0);
    pulse(0);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_addr", 0, 32'(addr[0]), 5);
    chk("stall_valid", 0, 32'(vld[0]), 1);
    chk("stall_index", 0, 32'(idx[0]), 0);
    chk("stall_busy", 0, 32'(busy[0]), 1);
    rdy[0] = 1'b1;
    wait_fin(0, 400);
    len_chk[0] = 259;
    // start edge while busy, then start held high across finish
    push_all(0);
    pulse(0);
    repeat (50) @(posedge clk);
    pulse(0);
    repeat (100) @(posedge clk);
    #1 strt[0] = 1'b1;
    wait_fin(0, 400);
    repeat (30) @(posedge clk);
    #1;
    chk("held_start_busy", 0, 32'(busy[0]), 0);
    chk("held_start_valid", 0, 32'(vld[0]), 0);
    strt[0] = 1'b0;
    push_all(0);
    pulse(0);
    wait_fin(0, 400);
    // asynchronous reset at word 100 aborts the pass without a finish pulse
    push_all(0);
    x0 = xfer[0];
    f0 = fin[0];
    pulse(0);
    n = 0;
    while (xfer[0] < x0 + 100 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("reach_word100", 0, 32'(xfer[0] >= x0 + 100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 0, 32'(vld[0]), 0);
    chk("async_busy", 0, 32'(busy[0]), 0);
    chk("async_out", 0, {16'b0, idx[0], dat[0]}, 0);
    chk("async_addr", 0, 32'(addr[0]), 0);
    q[0].delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_finish_on_reset", 0, fin[0], f0);
    chk("idle_after_reset", 0, 32'(busy[0]), 0);
    push_all(0);
    pulse(0);
    wait_fin(0, 400);
    // two-cycle latency with random backpressure
    push_all(1);
    f0 = fin[1];
    pulse(1);
    n = 0;
    while (fin[1] == f0 && n < 3000) begin
      @(posedge clk);
      #1 rdy[1] = 1'($urandom_range(0, 1));
      n++;
    end
    chk("finish_wait_rand", 1, 32'(fin[1] != f0), 1);
    rdy[1] = 1'b1;
    chk("rand_all_words", 1, xfer[1], 256);
    // single-word range
    q[2].push_back({8'd17, 8'hA5});
    pulse(2);
    wait_fin(2, 50);
    chk("single_count", 2, xfer[2], 1);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++) chk("final_queue", i, q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
